// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the FE/ID/EX pipeline.
// A one-bit-per-register scoreboard tracks writes that have issued but not retired.
// ID is stalled on RAW/WAW hazards, and FE/ID are flushed for FLUSH_CYCLES cycles
// after a taken branch. Saturating counters record stall and flush cycles.
module pipeline_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter bit R0_ZERO      = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  id_valid,
  input  logic                  id_reg_wr,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_use_r1,
  input  logic                  id_use_r2,
  input  logic [REG_ADDR_W-1:0] id_r1,
  input  logic [REG_ADDR_W-1:0] id_r2,
  input  logic                  ex_branch_taken,
  input  logic                  wb_wr,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  fe_stall,
  output logic                  id_stall,
  output logic                  fe_flush,
  output logic                  id_flush,
  output logic                  id_issue,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int         NREG     = 2 ** REG_ADDR_W;
  localparam bit         MULTI    = (FLUSH_CYCLES > 1);
  localparam logic [3:0] REM_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state_reg;
  logic [3:0]       rem_reg;
  logic [NREG-1:0]  pend_reg;
  logic [NREG-1:0]  pend_eff;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;
  logic             hz;
  logic             flush_raw;

  // Register 0 is masked out of the hazard view when it is hard-wired to zero.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_pend_eff
      if (R0_ZERO && gi == 0) begin : g_zero
        assign pend_eff[gi] = 1'b0;
      end else begin : g_norm
        assign pend_eff[gi] = pend_reg[gi];
      end
    end
  endgenerate

  // Hazard detection and flush/stall/issue priority; everything is gated low during reset.
  always_comb begin
    hz        = id_valid & ((id_use_r1 & pend_eff[id_r1]) |
                            (id_use_r2 & pend_eff[id_r2]) |
                            (id_reg_wr & pend_eff[id_rd]));
    flush_raw = (state_reg == FLUSH) | ex_branch_taken;
    fe_flush  = rst_n & flush_raw;
    id_flush  = rst_n & flush_raw;
    fe_stall  = rst_n & hz & ~flush_raw;
    id_stall  = rst_n & hz & ~flush_raw;
    id_issue  = rst_n & id_valid & ~hz & ~flush_raw & en;
  end

  // Flush sequencer: a taken branch flushes this cycle and holds the flush for the remaining cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      rem_reg   <= 4'd0;
    end else if (en) begin
      case (state_reg)
        RUN: begin
          if (ex_branch_taken && MULTI) begin
            state_reg <= FLUSH;
            rem_reg   <= REM_LOAD;
          end
        end
        FLUSH: begin
          if (ex_branch_taken) begin
            rem_reg <= REM_LOAD;
          end else if (rem_reg <= 4'd1) begin
            state_reg <= RUN;
          end else begin
            rem_reg <= rem_reg - 4'd1;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  // Scoreboard bits: set on issue of a write, cleared on writeback; set wins on a same-cycle collision.
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      logic set_bit;
      logic clr_bit;
      assign set_bit = id_issue & id_reg_wr & (id_rd == REG_ADDR_W'(gi)) & ~(R0_ZERO && gi == 0);
      assign clr_bit = wb_wr & (wb_rd == REG_ADDR_W'(gi));
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_reg[gi] <= 1'b0;
        end else if (en) begin
          if (set_bit) begin
            pend_reg[gi] <= 1'b1;
          end else if (clr_bit) begin
            pend_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (en) begin
      if (id_stall && (stall_cnt_reg != CNT_MAX)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (id_flush && (flush_cnt_reg != CNT_MAX)) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule
